// File: rtl/audio_info_frame_parser_if.sv
// rtl/audio_info_frame_parser_if.sv - packet byte stream bundle into the audio InfoFrame parser
interface audio_info_frame_parser_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       packet_start;

   modport master (
      output byte_in,
      output byte_valid,
      output packet_start
   );

   modport slave (
      input byte_in,
      input byte_valid,
      input packet_start
   );
endinterface

// File: rtl/audio_info_frame_parser.sv
// rtl/audio_info_frame_parser.sv - HDMI Audio InfoFrame receive parser (optional macro AUDIO_INFO_FRAME_RESERVED_CHECK_EN)
module audio_info_frame_parser #(
   parameter int MAX_BYTE_GAP = 63
) (
   input  logic                      clk_pixel,
   input  logic                      reset,
   audio_info_frame_parser_if.slave  in_if,
   output logic                      frame_valid,
   output logic                      frame_error,
   output logic [3:0]                error_code,
   output logic                      fields_present,
   output logic [3:0]                audio_coding_type,
   output logic [2:0]                audio_channel_count,
   output logic [2:0]                sampling_frequency,
   output logic [1:0]                sample_size,
   output logic [7:0]                channel_allocation,
   output logic                      down_mix_inhibited,
   output logic [3:0]                level_shift_value,
   output logic [1:0]                lfe_playback_level
);

   localparam int GAP_W = (MAX_BYTE_GAP > 1) ? $clog2(MAX_BYTE_GAP + 1) : 1;

   // Byte positions in the 31-byte packet stream
   localparam logic [4:0] IDX_HB1 = 5'd1;
   localparam logic [4:0] IDX_HB2 = 5'd2;
   localparam logic [4:0] IDX_PB1 = 5'd4;
   localparam logic [4:0] IDX_PB2 = 5'd5;
   localparam logic [4:0] IDX_PB4 = 5'd7;
   localparam logic [4:0] IDX_PB5 = 5'd8;
   localparam logic [4:0] IDX_PB27 = 5'd30;

   localparam logic [3:0] ERR_HEADER = 4'b0001;
   localparam logic [3:0] ERR_ABORT  = 4'b0100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_BODY
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic             hdr_ok_q, hdr_ok_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_inc;

   // Staging copies of only the field bits that reach the outputs
   logic [6:0]       stg_pb1_q, stg_pb1_d;   // {coding_type, channel_count}
   logic [4:0]       stg_pb2_q, stg_pb2_d;   // {sampling_frequency, sample_size}
   logic [7:0]       stg_pb4_q, stg_pb4_d;
   logic [6:0]       stg_pb5_q, stg_pb5_d;   // {dm_inh, lsv, lfe}

   logic             frame_valid_q, frame_valid_d;
   logic             frame_error_q, frame_error_d;
   logic [3:0]       error_code_q, error_code_d;
   logic             fields_present_q, fields_present_d;
   logic [3:0]       coding_type_q, coding_type_d;
   logic [2:0]       channel_count_q, channel_count_d;
   logic [2:0]       sampling_freq_q, sampling_freq_d;
   logic [1:0]       sample_size_q, sample_size_d;
   logic [7:0]       channel_alloc_q, channel_alloc_d;
   logic             dm_inh_q, dm_inh_d;
   logic [3:0]       lsv_q, lsv_d;
   logic [1:0]       lfe_q, lfe_d;

   logic [7:0]       sum_next;
   logic             start_hit;
   logic             rsv_now;

   assign sum_next  = sum_q + in_if.byte_in;
   assign start_hit = in_if.byte_valid & in_if.packet_start;
   assign gap_inc   = gap_q + 1'b1;

`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
   logic rsv_q, rsv_d, rsv_hit;

   // Flags nonzero content in reserved bit positions of the current body byte
   always_comb begin
      rsv_hit = 1'b0;
      case (idx_q)
         5'd4:    rsv_hit = in_if.byte_in[3];
         5'd5:    rsv_hit = |in_if.byte_in[7:5];
         5'd6:    rsv_hit = |in_if.byte_in;
         5'd8:    rsv_hit = in_if.byte_in[2];
         default: rsv_hit = (idx_q >= 5'd9) && (|in_if.byte_in);
      endcase
   end

   assign rsv_now = rsv_q | rsv_hit;
`else
   assign rsv_now = 1'b0;
`endif

   // Next-state logic: packet walk, header/checksum validation, field staging and commit
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      sum_d            = sum_q;
      hdr_ok_d         = hdr_ok_q;
      gap_d            = gap_q;
      stg_pb1_d        = stg_pb1_q;
      stg_pb2_d        = stg_pb2_q;
      stg_pb4_d        = stg_pb4_q;
      stg_pb5_d        = stg_pb5_q;
      frame_valid_d    = 1'b0;
      frame_error_d    = 1'b0;
      error_code_d     = 4'b0000;
      fields_present_d = fields_present_q;
      coding_type_d    = coding_type_q;
      channel_count_d  = channel_count_q;
      sampling_freq_d  = sampling_freq_q;
      sample_size_d    = sample_size_q;
      channel_alloc_d  = channel_alloc_q;
      dm_inh_d         = dm_inh_q;
      lsv_d            = lsv_q;
      lfe_d            = lfe_q;
`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
      rsv_d            = rsv_q;
`endif

      if (start_hit) begin
         // A new packet start always wins; an in-flight frame is reported as aborted
         if (state_q != ST_IDLE) begin
            frame_error_d = 1'b1;
            error_code_d  = ERR_ABORT;
         end
         state_d  = ST_HEADER;
         idx_d    = 5'd1;
         sum_d    = in_if.byte_in;
         hdr_ok_d = (in_if.byte_in == 8'h84);
         gap_d    = '0;
`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
         rsv_d    = 1'b0;
`endif
      end else if (state_q != ST_IDLE) begin
         if (in_if.byte_valid) begin
            gap_d = '0;
            sum_d = sum_next;
            idx_d = idx_q + 5'd1;
            if (state_q == ST_HEADER) begin
               if (idx_q == IDX_HB1) begin
                  hdr_ok_d = hdr_ok_q & (in_if.byte_in == 8'h01);
               end else if (idx_q == IDX_HB2) begin
                  if (hdr_ok_q && (in_if.byte_in == 8'h0A)) begin
                     state_d = ST_BODY;
                  end else begin
                     state_d       = ST_IDLE;
                     frame_error_d = 1'b1;
                     error_code_d  = ERR_HEADER;
                  end
               end
            end else begin
`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
               rsv_d = rsv_now;
`endif
               case (idx_q)
                  IDX_PB1: stg_pb1_d = {in_if.byte_in[7:4], in_if.byte_in[2:0]};
                  IDX_PB2: stg_pb2_d = in_if.byte_in[4:0];
                  IDX_PB4: stg_pb4_d = in_if.byte_in;
                  IDX_PB5: stg_pb5_d = {in_if.byte_in[7:3], in_if.byte_in[1:0]};
                  default: ;
               endcase
               if (idx_q == IDX_PB27) begin
                  state_d = ST_IDLE;
                  if (rsv_now || (sum_next != 8'h00)) begin
                     frame_error_d = 1'b1;
                     error_code_d  = {rsv_now, 1'b0, (sum_next != 8'h00), 1'b0};
                  end else begin
                     frame_valid_d    = 1'b1;
                     fields_present_d = 1'b1;
                     coding_type_d    = stg_pb1_q[6:3];
                     channel_count_d  = stg_pb1_q[2:0];
                     sampling_freq_d  = stg_pb2_q[4:2];
                     sample_size_d    = stg_pb2_q[1:0];
                     channel_alloc_d  = stg_pb4_q;
                     dm_inh_d         = stg_pb5_q[6];
                     lsv_d            = stg_pb5_q[5:2];
                     lfe_d            = stg_pb5_q[1:0];
                  end
               end
            end
         end else if (MAX_BYTE_GAP != 0) begin
            // Idle cycle inside a packet: abort once the gap budget is used up
            if (gap_inc == GAP_W'(MAX_BYTE_GAP)) begin
               state_d       = ST_IDLE;
               gap_d         = '0;
               frame_error_d = 1'b1;
               error_code_d  = ERR_ABORT;
            end else begin
               gap_d = gap_inc;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         idx_q            <= 5'd0;
         sum_q            <= 8'h00;
         hdr_ok_q         <= 1'b0;
         gap_q            <= '0;
         stg_pb1_q        <= 7'h00;
         stg_pb2_q        <= 5'h00;
         stg_pb4_q        <= 8'h00;
         stg_pb5_q        <= 7'h00;
         frame_valid_q    <= 1'b0;
         frame_error_q    <= 1'b0;
         error_code_q     <= 4'b0000;
         fields_present_q <= 1'b0;
         coding_type_q    <= 4'h0;
         channel_count_q  <= 3'd0;
         sampling_freq_q  <= 3'd0;
         sample_size_q    <= 2'd0;
         channel_alloc_q  <= 8'h00;
         dm_inh_q         <= 1'b0;
         lsv_q            <= 4'h0;
         lfe_q            <= 2'd0;
`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
         rsv_q            <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         sum_q            <= sum_d;
         hdr_ok_q         <= hdr_ok_d;
         gap_q            <= gap_d;
         stg_pb1_q        <= stg_pb1_d;
         stg_pb2_q        <= stg_pb2_d;
         stg_pb4_q        <= stg_pb4_d;
         stg_pb5_q        <= stg_pb5_d;
         frame_valid_q    <= frame_valid_d;
         frame_error_q    <= frame_error_d;
         error_code_q     <= error_code_d;
         fields_present_q <= fields_present_d;
         coding_type_q    <= coding_type_d;
         channel_count_q  <= channel_count_d;
         sampling_freq_q  <= sampling_freq_d;
         sample_size_q    <= sample_size_d;
         channel_alloc_q  <= channel_alloc_d;
         dm_inh_q         <= dm_inh_d;
         lsv_q            <= lsv_d;
         lfe_q            <= lfe_d;
`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
         rsv_q            <= rsv_d;
`endif
      end
   end

   assign frame_valid         = frame_valid_q;
   assign frame_error         = frame_error_q;
   assign error_code          = error_code_q;
   assign fields_present      = fields_present_q;
   assign audio_coding_type   = coding_type_q;
   assign audio_channel_count = channel_count_q;
   assign sampling_frequency  = sampling_freq_q;
   assign sample_size         = sample_size_q;
   assign channel_allocation  = channel_alloc_q;
   assign down_mix_inhibited  = dm_inh_q;
   assign level_shift_value   = lsv_q;
   assign lfe_playback_level  = lfe_q;

endmodule

// File: tb/tb_audio_info_frame_parser.sv
// tb/tb_audio_info_frame_parser.sv - directed self-checking bench for audio_info_frame_parser
module tb_audio_info_frame_parser;

   logic       clk_pixel = 1'b0;
   logic       reset = 1'b1;
   logic       frame_valid, frame_error, fields_present;
   logic [3:0] error_code, audio_coding_type, level_shift_value;
   logic [2:0] audio_channel_count, sampling_frequency;
   logic [1:0] sample_size, lfe_playback_level;
   logic [7:0] channel_allocation;
   logic       down_mix_inhibited;

   audio_info_frame_parser_if bus();

   audio_info_frame_parser #(.MAX_BYTE_GAP(63)) dut (
      .clk_pixel           (clk_pixel),
      .reset               (reset),
      .in_if               (bus),
      .frame_valid         (frame_valid),
      .frame_error         (frame_error),
      .error_code          (error_code),
      .fields_present      (fields_present),
      .audio_coding_type   (audio_coding_type),
      .audio_channel_count (audio_channel_count),
      .sampling_frequency  (sampling_frequency),
      .sample_size         (sample_size),
      .channel_allocation  (channel_allocation),
      .down_mix_inhibited  (down_mix_inhibited),
      .level_shift_value   (level_shift_value),
      .lfe_playback_level  (lfe_playback_level)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_checks = 0;
   int n_fail = 0;
   int n_valid = 0;
   int n_err = 0;
   int n_both = 0;
   logic [3:0] last_code = 4'h0;
   logic [7:0] frm [0:30];

   // Pulse monitor sampled on the falling edge
   always @(negedge clk_pixel) begin
      if (!reset) begin
         if (frame_valid) n_valid++;
         if (frame_error) begin
            n_err++;
            last_code = error_code;
         end
         if (frame_valid && frame_error) n_both++;
      end
   end

   task automatic idle(input int n);
      bus.byte_valid   = 1'b0;
      bus.packet_start = 1'b0;
      repeat (n) begin
         @(posedge clk_pixel);
         #1;
      end
   endtask

   task automatic load_frame(input logic [7:0] pb0, input logic [7:0] pb1,
                             input logic [7:0] pb4, input logic [7:0] pb5);
      for (int i = 0; i < 31; i++) frm[i] = 8'h00;
      frm[0] = 8'h84; frm[1] = 8'h01; frm[2] = 8'h0A;
      frm[3] = pb0; frm[4] = pb1; frm[7] = pb4; frm[8] = pb5;
   endtask

   task automatic send_bytes(input int first, input int last, input int gap_at, input int gap_len);
      for (int i = first; i <= last; i++) begin
         if (i == gap_at) idle(gap_len);
         bus.byte_in      = frm[i];
         bus.byte_valid   = 1'b1;
         bus.packet_start = (i == 0);
         @(posedge clk_pixel);
         #1;
      end
      bus.byte_valid   = 1'b0;
      bus.packet_start = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      // intentionally unused helper avoided; see inline checks
   endtask

   task automatic test_reset;
      n_checks++;
      if ({frame_valid, frame_error, error_code} !== 6'b0) begin
         n_fail++; $display("FAIL reset_pulses got=%b exp=0", {frame_valid, frame_error, error_code});
      end
      n_checks++;
      if ({fields_present, audio_coding_type, audio_channel_count, sampling_frequency, sample_size,
           channel_allocation, down_mix_inhibited, level_shift_value, lfe_playback_level} !== 28'h0) begin
         n_fail++; $display("FAIL reset_fields got=nonzero exp=0");
      end
   endtask

   task automatic test_default_stereo;
      load_frame(8'h70, 8'h01, 8'h00, 8'h00);
      send_bytes(0, 30, -1, 0);
      n_checks++;
      if (frame_valid !== 1'b1 || frame_error !== 1'b0) begin
         n_fail++; $display("FAIL stereo_latency got=v%b e%b exp=v1 e0", frame_valid, frame_error);
      end
      n_checks++;
      if (audio_channel_count !== 3'd1 || channel_allocation !== 8'h00 || fields_present !== 1'b1) begin
         n_fail++; $display("FAIL stereo_fields got=%0d/%h/%b exp=1/00/1", audio_channel_count, channel_allocation, fields_present);
      end
      idle(1);
      n_checks++;
      if (frame_valid !== 1'b0) begin
         n_fail++; $display("FAIL stereo_pulse_width got=%b exp=0", frame_valid);
      end
      idle(2);
   endtask

   task automatic test_surround;
      load_frame(8'hE9, 8'h05, 8'h0B, 8'h78);
      send_bytes(0, 30, -1, 0);
      n_checks++;
      if (frame_valid !== 1'b1) begin
         n_fail++; $display("FAIL surround_valid got=%b exp=1", frame_valid);
      end
      n_checks++;
      if (audio_channel_count !== 3'd5 || channel_allocation !== 8'h0B || level_shift_value !== 4'd15
          || down_mix_inhibited !== 1'b0 || lfe_playback_level !== 2'd0) begin
         n_fail++; $display("FAIL surround_fields got=%0d/%h/%0d/%b/%0d exp=5/0b/15/0/0",
            audio_channel_count, channel_allocation, level_shift_value, down_mix_inhibited, lfe_playback_level);
      end
      idle(2);
   endtask

   task automatic test_checksum_error;
      load_frame(8'hEA, 8'h05, 8'h0B, 8'h78);
      send_bytes(0, 30, -1, 0);
      n_checks++;
      if (frame_error !== 1'b1 || frame_valid !== 1'b0 || error_code !== 4'b0010) begin
         n_fail++; $display("FAIL checksum_err got=e%b v%b code=%b exp=e1 v0 code=0010", frame_error, frame_valid, error_code);
      end
      n_checks++;
      if (audio_channel_count !== 3'd5 || channel_allocation !== 8'h0B || level_shift_value !== 4'd15) begin
         n_fail++; $display("FAIL checksum_hold got=%0d/%h/%0d exp=5/0b/15", audio_channel_count, channel_allocation, level_shift_value);
      end
      idle(2);
   endtask

   task automatic test_header_error;
      int v0, e0;
      load_frame(8'h70, 8'h01, 8'h00, 8'h00);
      frm[0] = 8'h82;
      send_bytes(0, 2, -1, 0);
      n_checks++;
      if (frame_error !== 1'b1 || error_code !== 4'b0001) begin
         n_fail++; $display("FAIL header_err got=e%b code=%b exp=e1 code=0001", frame_error, error_code);
      end
      idle(1);
      v0 = n_valid; e0 = n_err;
      send_bytes(3, 30, -1, 0);
      idle(2);
      n_checks++;
      if (n_valid != v0 || n_err != e0) begin
         n_fail++; $display("FAIL header_tail_ignored got=v%0d e%0d exp=v0 e0", n_valid - v0, n_err - e0);
      end
      frm[0] = 8'h84;
      send_bytes(0, 30, -1, 0);
      n_checks++;
      if (frame_valid !== 1'b1 || audio_channel_count !== 3'd1) begin
         n_fail++; $display("FAIL header_recover got=v%b cc=%0d exp=v1 cc=1", frame_valid, audio_channel_count);
      end
      idle(2);
   endtask

   task automatic test_abort;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_frame(8'h70, 8'h01, 8'h00, 8'h00);
      send_bytes(0, 14, -1, 0);
      load_frame(8'hE9, 8'h05, 8'h0B, 8'h78);
      send_bytes(0, 30, -1, 0);
      idle(2);
      n_checks++;
      if (n_err - e0 != 1 || last_code !== 4'b0100) begin
         n_fail++; $display("FAIL abort_err got=%0d code=%b exp=1 code=0100", n_err - e0, last_code);
      end
      n_checks++;
      if (n_valid - v0 != 1 || audio_channel_count !== 3'd5 || channel_allocation !== 8'h0B) begin
         n_fail++; $display("FAIL abort_new_frame got=%0d cc=%0d ca=%h exp=1 cc=5 ca=0b", n_valid - v0, audio_channel_count, channel_allocation);
      end
   endtask

   task automatic test_timeout;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_frame(8'h70, 8'h01, 8'h00, 8'h00);
      send_bytes(0, 30, 10, 63);
      idle(2);
      n_checks++;
      if (n_err - e0 != 1 || last_code !== 4'b0100 || n_valid != v0) begin
         n_fail++; $display("FAIL timeout_63 got=e%0d v%0d code=%b exp=e1 v0 code=0100", n_err - e0, n_valid - v0, last_code);
      end
      n_checks++;
      if (audio_channel_count !== 3'd5) begin
         n_fail++; $display("FAIL timeout_hold got=%0d exp=5", audio_channel_count);
      end
      v0 = n_valid; e0 = n_err;
      send_bytes(0, 30, 10, 62);
      idle(2);
      n_checks++;
      if (n_valid - v0 != 1 || n_err != e0 || audio_channel_count !== 3'd1) begin
         n_fail++; $display("FAIL timeout_62 got=v%0d e%0d cc=%0d exp=v1 e0 cc=1", n_valid - v0, n_err - e0, audio_channel_count);
      end
   endtask

   task automatic test_reserved;
      load_frame(8'h6F, 8'h01, 8'h00, 8'h00);
      frm[13] = 8'h01;
      send_bytes(0, 30, -1, 0);
`ifdef AUDIO_INFO_FRAME_RESERVED_CHECK_EN
      n_checks++;
      if (frame_error !== 1'b1 || frame_valid !== 1'b0 || error_code !== 4'b1000) begin
         n_fail++; $display("FAIL reserved_err got=e%b v%b code=%b exp=e1 v0 code=1000", frame_error, frame_valid, error_code);
      end
`else
      n_checks++;
      if (frame_valid !== 1'b1 || frame_error !== 1'b0) begin
         n_fail++; $display("FAIL reserved_ignored got=v%b e%b exp=v1 e0", frame_valid, frame_error);
      end
`endif
      idle(2);
   endtask

   task automatic test_back_to_back;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_frame(8'hE9, 8'h05, 8'h0B, 8'h78);
      send_bytes(0, 30, -1, 0);
      load_frame(8'h70, 8'h01, 8'h00, 8'h00);
      send_bytes(0, 30, -1, 0);
      idle(2);
      n_checks++;
      if (n_valid - v0 != 2 || n_err != e0 || audio_channel_count !== 3'd1) begin
         n_fail++; $display("FAIL back_to_back got=v%0d e%0d cc=%0d exp=v2 e0 cc=1", n_valid - v0, n_err - e0, audio_channel_count);
      end
   endtask

   task automatic test_reset_mid_packet;
      int v0, e0;
      load_frame(8'hE9, 8'h05, 8'h0B, 8'h78);
      send_bytes(0, 9, -1, 0);
      v0 = n_valid; e0 = n_err;
      reset = 1'b1;
      idle(2);
      n_checks++;
      if (frame_valid !== 1'b0 || frame_error !== 1'b0 || fields_present !== 1'b0 || audio_channel_count !== 3'd0) begin
         n_fail++; $display("FAIL reset_mid got=v%b e%b fp%b cc=%0d exp=0/0/0/0", frame_valid, frame_error, fields_present, audio_channel_count);
      end
      reset = 1'b0;
      send_bytes(10, 30, -1, 0);
      idle(2);
      n_checks++;
      if (n_valid != v0 || n_err != e0) begin
         n_fail++; $display("FAIL reset_mid_no_pulse got=v%0d e%0d exp=0/0", n_valid - v0, n_err - e0);
      end
      send_bytes(0, 30, -1, 0);
      n_checks++;
      if (frame_valid !== 1'b1 || audio_channel_count !== 3'd5 || fields_present !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_recover got=v%b cc=%0d fp=%b exp=1/5/1", frame_valid, audio_channel_count, fields_present);
      end
      idle(2);
   endtask

   initial begin
      bus.byte_in      = 8'h00;
      bus.byte_valid   = 1'b0;
      bus.packet_start = 1'b0;
      reset = 1'b1;
      idle(3);
      test_reset();
      reset = 1'b0;
      idle(2);
      test_default_stereo();
      test_surround();
      test_checksum_error();
      test_header_error();
      test_abort();
      test_timeout();
      test_reserved();
      test_back_to_back();
      test_reset_mid_packet();
      n_checks++;
      if (n_both != 0) begin
         n_fail++; $display("FAIL exclusive_pulses got=%0d exp=0", n_both);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
